// File: rtl/mem_wr_packer_if.sv
// rtl/mem_wr_packer_if.sv - byte-stream in / word-write out bundle for mem_wr_packer
//
// Purpose: groups the load control, the upstream byte stream and the
// memory write port of mem_wr_packer into one interface.
//
// Signals:
//   start     load start pulse                          (master -> slave)
//   in_valid  byte stream valid                         (master -> slave)
//   in_data   byte stream data, 8 bits                  (master -> slave)
//   in_last   marks the final byte of the load          (master -> slave)
//   in_ready  packer accepts a byte this cycle          (slave -> master)
//   wen       one-cycle write strobe                    (slave -> master)
//   waddr     16-bit word address                       (slave -> master)
//   wdata     64-bit word data                          (slave -> master)
//   done      load complete, level                      (slave -> master)
//   word_cnt  17-bit count of words written this load   (slave -> master)
//
// Modports: slave is the packer's view, master is the view of whatever
// drives the byte stream and observes the memory port.

interface mem_wr_packer_if;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        wen;
  logic [15:0] waddr;
  logic [63:0] wdata;
  logic        done;
  logic [16:0] word_cnt;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, wen, waddr, wdata, done, word_cnt
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, wen, waddr, wdata, done, word_cnt
  );
endinterface

// File: rtl/mem_wr_packer.sv
// rtl/mem_wr_packer.sv - packs an 8-bit byte stream into 64-bit memory word writes
//
// Purpose: after a start pulse, accepts bytes from an upstream valid/ready
// stream, packs eight of them MSB-first into a 64-bit word and writes each
// word to consecutive addresses of a 64K x 64 memory, beginning at
// BASE_ADDR. A load ends after NUM_WORDS words or when a byte flagged
// in_last has been taken; done then stays high until the next start.
//
// Parameters:
//   BASE_ADDR  first word address of each load (16 bits)
//   NUM_WORDS  words per load, 1..65536 (17 bits)
//
// Ports:
//   clk    rising-edge clock, the only clock
//   rst_n  asynchronous active-low reset
//   bus    mem_wr_packer_if.slave: start, in_valid/in_ready/in_data/in_last,
//          wen/waddr/wdata, done, word_cnt
//
// Configuration macro MEM_WR_PACKER_PAD_EN:
//   defined   - a partial word ended by in_last is written with its unfilled
//               low bytes zero, and the load then completes
//   undefined - such a partial word is dropped without a write and the load
//               completes; word_cnt does not count it

module mem_wr_packer #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [16:0] NUM_WORDS = 17'd65536
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_wr_packer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q,    state_d;
  logic [2:0]  byte_idx_q, byte_idx_d;   // slot of the next byte in the word
  logic [63:0] pack_q,     pack_d;       // word being assembled
  logic [15:0] addr_q,     addr_d;       // address the next write goes to
  logic [15:0] waddr_q,    waddr_d;      // address of the most recent write
  logic [16:0] word_cnt_q, word_cnt_d;
  logic        last_q,     last_d;       // word in pack_q ends the load

  logic [16:0] word_cnt_inc;
  logic [63:0] byte_placed;

  assign word_cnt_inc = word_cnt_q + 17'd1;

  // Byte k lands in bits [63-8k -: 8]: shift a top-aligned byte right by 8k.
  assign byte_placed = {bus.in_data, 56'd0} >> {byte_idx_q, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_idx_q <= 3'd0;
      pack_q     <= 64'd0;
      addr_q     <= BASE_ADDR;
      waddr_q    <= BASE_ADDR;
      word_cnt_q <= 17'd0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      pack_q     <= pack_d;
      addr_q     <= addr_d;
      waddr_q    <= waddr_d;
      word_cnt_q <= word_cnt_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    pack_d     = pack_q;
    addr_d     = addr_q;
    waddr_d    = waddr_q;
    word_cnt_d = word_cnt_q;
    last_d     = last_q;

    case (state_q)
      IDLE, DONE: begin
        // waddr_q keeps showing the last written address across loads.
        if (bus.start) begin
          state_d    = FILL;
          byte_idx_d = 3'd0;
          pack_d     = 64'd0;
          addr_d     = BASE_ADDR;
          word_cnt_d = 17'd0;
          last_d     = 1'b0;
        end
      end

      FILL: begin
        // start is deliberately not looked at here.
        if (bus.in_valid) begin
          // pack_q is cleared at the start of every word, so OR-ing is
          // enough and any unfilled low bytes stay zero.
          pack_d     = pack_q | byte_placed;
          byte_idx_d = byte_idx_q + 3'd1;
          last_d     = bus.in_last;
          if (byte_idx_q == 3'd7) begin
            state_d = WRITE;
          end else if (bus.in_last) begin
`ifdef MEM_WR_PACKER_PAD_EN
            state_d = WRITE;
`else
            state_d = DONE;
            pack_d  = 64'd0;
`endif
          end
        end
      end

      WRITE: begin
        waddr_d    = addr_q;
        addr_d     = addr_q + 16'd1;   // natural wrap 0xFFFF -> 0x0000
        word_cnt_d = word_cnt_inc;
        pack_d     = 64'd0;
        byte_idx_d = 3'd0;
        // A start seen here is dropped; the load still finishes normally.
        if ((word_cnt_inc == NUM_WORDS) || last_q) begin
          state_d = DONE;
        end else begin
          state_d = FILL;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs decode registered state, so reset reaches them at once.
  assign bus.in_ready = (state_q == FILL);
  assign bus.wen      = (state_q == WRITE);
  assign bus.waddr    = (state_q == WRITE) ? addr_q : waddr_q;
  assign bus.wdata    = (state_q == WRITE) ? pack_q : 64'd0;
  assign bus.done     = (state_q == DONE);
  assign bus.word_cnt = word_cnt_q;

endmodule

// File: doc/mem_wr_packer.md
MEM_WR_PACKER -- requirements
Module: mem_wr_packer

Interface
REQ-001 SHALL have parameters: BASE_ADDR, 16'h0000, first word address written; NUM_WORDS, 17'd65536, words per load (1..65536).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock, the only clock.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: start  in  1  one-cycle pulse, begins a load.
REQ-005 SHALL have ports: in_valid  in  1; in_ready  out  1; in_data  in  8; in_last  in  1; byte stream, transfer when in_valid & in_ready.
REQ-006 SHALL have ports: wen  out  1  write strobe to 64Kx64 word memory.
REQ-007 SHALL have ports: waddr  out  16  write word address; wdata  out  64  write data.
REQ-008 SHALL have ports: done  out  1  load complete (level); word_cnt  out  17  words written this load.

Function
REQ-009 SHALL implement FSM IDLE, FILL, WRITE, DONE.
REQ-010 SHALL go IDLE/DONE -> FILL on start: byte index 0, word_cnt 0, address BASE_ADDR, done cleared.
REQ-011 SHALL ignore start in FILL and WRITE.
REQ-012 SHALL drive in_ready high only in FILL.
REQ-013 SHALL pack bytes MSB-first: byte k of a word -> bits [63-8k -: 8], k = 0..7, matching the bit order of the mask file read back by gap_tv.
REQ-014 SHALL go FILL -> WRITE on acceptance of byte 7, or on acceptance of any byte with in_last high (subject to REQ-026).
REQ-015 SHALL assert wen for exactly one cycle in WRITE: waddr = current address, wdata = packed word. Latency: 1 cycle after the completing byte is accepted.
REQ-016 SHALL drive wdata = 64'd0 whenever wen is low.
REQ-017 SHALL drive waddr = last written address whenever wen is low.
REQ-018 SHALL, after each write, increment word_cnt and increment the address modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-019 SHALL go WRITE -> DONE when word_cnt reaches NUM_WORDS or the word contained in_last; otherwise go WRITE -> FILL with byte index 0.
REQ-020 SHALL hold done high in DONE until the next start.
REQ-021 SHALL ignore bytes presented while in_ready is low; upstream holds them.
REQ-022 SHALL treat in_last on byte 7 as a normal full-word write followed by DONE.
REQ-023 SHALL treat a start asserted in the same cycle as DONE entry as ignored; the FSM enters DONE.

Reset
REQ-024 SHALL on rst_n low, immediately and asynchronously: state IDLE, in_ready 0, wen 0, waddr BASE_ADDR, wdata 0, done 0, word_cnt 0, pack register 0.
REQ-025 SHALL, when reset is asserted mid-load, abandon the partial word with no write and require a new start after release.

Configuration
REQ-026 SHALL support macro MEM_WR_PACKER_PAD_EN. Defined: a partial word ended by in_last is zero-padded in the unfilled low bytes, written, then DONE. Undefined: the partial word is discarded (no wen), FSM goes FILL -> DONE, and word_cnt excludes it.

Verification
REQ-027 SHALL check: reset, start, 8 bytes 01..08 with no gaps -> one wen at waddr 0x0000, wdata 0x0102030405060708; done low; in_ready low for 1 cycle.
REQ-028 SHALL check: NUM_WORDS=2, 16 bytes with in_valid toggling every other cycle -> writes at 0x0000 and 0x0001; done high and word_cnt 2 after the second write.
REQ-029 SHALL check: BASE_ADDR=16'hFFFF, NUM_WORDS=2, 16 bytes -> writes at 0xFFFF then 0x0000.
REQ-030 SHALL check: 3 bytes AA,BB,CC with in_last on CC. With PAD_EN: wdata 0xAABBCC0000000000, word_cnt 1. Without PAD_EN: no wen, done high, word_cnt 0.
REQ-031 SHALL check: rst_n pulsed low after 5 bytes -> outputs take reset values within the same cycle; no wen; subsequent start plus 8 bytes writes at BASE_ADDR.
REQ-032 SHALL check: start pulsed during FILL -> ignored, packing and address unchanged.
